div_unit: RTL

Multi-cycle radix-2 restoring divider with its own sequencing FSM. It serves the EX stage for DIV/DIVU: EX raises start with latched operands, holds its pipeline stall request until `ready_o`, then captures `{remainder, quotient}` for HI/LO. One divide is in flight at a time. An annul input lets control abandon an in-progress divide on flush.

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit_if.sv | 22 ++
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and encodings for the multi-cycle divider.
package div_unit_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // {remainder, quotient} as handed back to HI/LO
    typedef logic [2*DATA_W-1:0] double_reg_bus_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage and the divider.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift R:Q left, trial-subtract D, set quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH+1:0] r_shift;
    logic [WIDTH:0]   diff;
    logic             no_borrow;

    always_comb begin
        r_shift = {r_i, q_i[WIDTH-1]};
        diff    = r_shift[WIDTH:0] - {1'b0, d_i};
        // With the shifted-in top bit set the trial always fits; otherwise diff's MSB is the borrow.
        no_borrow = ~r_shift[WIDTH+1] & (r_shift[WIDTH] | ~diff[WIDTH]);
        r_o = no_borrow ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
        q_o = {q_i[WIDTH-2:0], no_borrow};
    end
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU with sequencing FSM, annul and sign fix-up.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned RES_W = 2 * WIDTH;

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] r_nxt, q_nxt;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_nxt),
        .q_o (q_nxt)
    );

    // Operand magnitudes; the most negative value maps onto its own unsigned pattern.
    always_comb begin
        op1_mag = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? WIDTH'(0) - bus.opdata1_i
                                                               : bus.opdata1_i;
        op2_mag = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? WIDTH'(0) - bus.opdata2_i
                                                               : bus.opdata2_i;
        quo_fix = neg_quo_q ? WIDTH'(0) - q_nxt : q_nxt;
        rem_fix = neg_rem_q ? WIDTH'(0) - r_nxt : r_nxt;
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        neg_quo_d = bus.signed_div_i &
                                    (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        neg_rem_d = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                        q_d       = op1_mag;
                        d_d       = op2_mag;
                        r_d       = '0;
                        cnt_d     = '0;
                    end
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = '0;
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    r_d   = {1'b0, r_nxt};
                    q_d   = q_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DivEnd;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = DivResultReady;
                    end
                end
            end
            DivEnd: begin
                if (bus.start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: begin
                state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule
